// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Parses 0xA5 / LEN / payload / CHK frames arriving as one-cycle byte strobes
// from a UART receiver, buffers the payload and replays it to a consumer over
// a valid/ready stream once the checksum has been confirmed. Framing problems
// (bad length, bad checksum, inter-byte timeout, byte arriving while the
// previous frame is still being replayed) are reported as a one-cycle
// frame_err pulse with the cause held in err_code.
module uart_frame_decoder #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 8680
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam int                IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]        LEN_MAX  = 8'(MAX_LEN);
  localparam logic [7:0]        SOF      = 8'hA5;
  localparam logic [1:0]        ERR_OVR  = 2'b00;
  localparam logic [1:0]        ERR_LEN  = 2'b01;
  localparam logic [1:0]        ERR_CHK  = 2'b10;
  localparam logic [1:0]        ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_LEN = 3'd1,
    GET_PAY = 3'd2,
    GET_CHK = 3'd3,
    SEND    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       len;
  logic [7:0]       wr_idx;
  logic [7:0]       rd_idx;
  logic [7:0]       sum;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       buffer [MAX_LEN];
  logic             ok_set;
  logic             err_set;
  logic [1:0]       err_sel;
  logic             tmo_hit;
  logic             len_bad;
  logic             xfer;

  // Checksum accumulation wraps modulo 256 by construction of the 8-bit result.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // A byte in the timeout cycle wins, so the timeout only fires with no strobe.
  assign tmo_hit   = !rx_valid && (tmo_cnt == TMO_LAST);
  assign len_bad   = (rx_data == 8'h00) || (rx_data > LEN_MAX);
  assign out_valid = (state == SEND);
  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid && (rd_idx == len - 8'd1);
  assign out_data  = out_valid ? buffer[rd_idx[IDX_W-1:0]] : 8'h00;
  assign busy      = (state != IDLE);

  // Next-state and event decode for the frame parser.
  always_comb begin
    state_nxt = state;
    ok_set    = 1'b0;
    err_set   = 1'b0;
    err_sel   = err_code;
    case (state)
      IDLE: begin
        if (rx_valid && rx_data == SOF) state_nxt = GET_LEN;
      end
      GET_LEN: begin
        if (rx_valid) begin
          if (len_bad) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
            err_sel   = ERR_LEN;
          end else begin
            state_nxt = GET_PAY;
          end
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
          err_sel   = ERR_TMO;
        end
      end
      GET_PAY: begin
        if (rx_valid) begin
          if (wr_idx == len - 8'd1) state_nxt = GET_CHK;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
          err_sel   = ERR_TMO;
        end
      end
      GET_CHK: begin
        if (rx_valid) begin
          if (rx_data == sum) begin
            state_nxt = SEND;
            ok_set    = 1'b1;
          end else begin
            state_nxt = IDLE;
            err_set   = 1'b1;
            err_sel   = ERR_CHK;
          end
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
          err_sel   = ERR_TMO;
        end
      end
      SEND: begin
        if (rx_valid) begin
          err_set = 1'b1;
          err_sel = ERR_OVR;
        end
        if (xfer && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the registered status pulses and sticky error cause.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_OVR;
    end else begin
      state     <= state_nxt;
      frame_ok  <= ok_set;
      frame_err <= err_set;
      if (err_set) err_code <= err_sel;
    end
  end

  // Length, indices, running checksum and inter-byte timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len     <= 8'h00;
      wr_idx  <= 8'h00;
      rd_idx  <= 8'h00;
      sum     <= 8'h00;
      tmo_cnt <= '0;
    end else begin
      if (state == GET_LEN || state == GET_PAY || state == GET_CHK)
        tmo_cnt <= rx_valid ? '0 : tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      case (state)
        IDLE: begin
          wr_idx <= 8'h00;
          rd_idx <= 8'h00;
        end
        GET_LEN: begin
          if (rx_valid) begin
            len    <= rx_data;
            sum    <= rx_data;
            wr_idx <= 8'h00;
          end
        end
        GET_PAY: begin
          if (rx_valid) begin
            sum    <= chk_add(sum, rx_data);
            wr_idx <= wr_idx + 8'd1;
          end
        end
        SEND: begin
          if (xfer) rd_idx <= rd_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Payload storage; contents are only meaningful between LEN and end of SEND.
  always_ff @(posedge clk) begin
    if (state == GET_PAY && rx_valid) buffer[wr_idx[IDX_W-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder
// Scenario tasks drive byte strobes into uart_frame_decoder; a negedge monitor
// records transfers and status pulses, and a frame-level reference parser
// derives the expected payload stream and status counts from the bytes sent.
module tb_uart_frame_decoder;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int ready_mode = 1;

  logic [7:0] frame_q[$];
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  int         exp_ok = 0;
  int         exp_err = 0;
  logic [1:0] exp_code = 2'b00;

  logic [7:0] got_q[$];
  logic       last_q[$];
  int         xfer_cyc[$];
  int         cyc = 0;
  int         ok_cnt = 0;
  int         err_cnt = 0;
  int         ov_cnt = 0;
  int         ok_cyc = 0;
  int         excl_bad = 0;
  int         hold_bad = 0;
  int         okvalid_bad = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  uart_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Consumer readiness: 0 stalled, 1 always ready, otherwise random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: record transfers, pulses and stall stability at the quiet edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        xfer_cyc.push_back(cyc);
      end
      if (out_valid) ov_cnt++;
      if (frame_ok) begin
        ok_cnt++;
        ok_cyc = cyc;
        if (!out_valid) okvalid_bad++;
      end
      if (frame_err) err_cnt++;
      if (frame_ok && frame_err) excl_bad++;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        hold_bad++;
    end
    prev_stall = rst && out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame_q[i]) begin
      stim_q.push_back(frame_q[i]);
      send_byte(frame_q[i]);
      if (gaps) idle(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic wait_idle(output bit tmo);
    int n = 0;
    while (busy && n < 400) begin
      idle(1);
      n++;
    end
    tmo = busy;
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    xfer_cyc.delete();
    stim_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    ok_cnt  = 0;
    err_cnt = 0;
    ov_cnt  = 0;
    exp_ok  = 0;
    exp_err = 0;
  endtask

  // Frame-level reference: walk the sent byte list using the framing rules.
  task automatic model_run();
    int i = 0;
    int n = stim_q.size();
    while (i < n) begin
      if (stim_q[i] != 8'hA5) i++;
      else if (i + 1 >= n) i = n;
      else begin
        int flen = int'(stim_q[i+1]);
        if (flen == 0 || flen > MAX_LEN) begin
          exp_err++;
          exp_code = 2'b01;
          i += 2;
        end else if (i + 2 + flen >= n) i = n;
        else begin
          int s = flen;
          for (int k = 0; k < flen; k++) s += int'(stim_q[i+2+k]);
          if ((s % 256) == int'(stim_q[i+2+flen])) begin
            exp_ok++;
            for (int k = 0; k < flen; k++) begin
              exp_q.push_back(stim_q[i+2+k]);
              exp_last_q.push_back(k == flen - 1);
            end
          end else begin
            exp_err++;
            exp_code = 2'b10;
          end
          i += 3 + flen;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b want=00", frame_ok, frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (out_data !== 8'h00 || err_code !== 2'b00) begin errors++; $display("FAIL reset_data_code got=%h/%b want=00/00", out_data, err_code); end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    bit tmo;
    clear_mon();
    ready_mode = 1;
    idle(2);
    frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_frame(1'b0);
    wait_idle(tmo);
    model_run();
    checks++; if (tmo) begin errors++; $display("FAIL good_drain busy stuck got=1 want=0"); end
    checks++; if (ok_cnt !== exp_ok) begin errors++; $display("FAIL good_ok_count got=%0d want=%0d", ok_cnt, exp_ok); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL good_len got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k] || last_q[k] !== exp_last_q[k]) begin
        errors++; $display("FAIL good_byte[%0d] got=%h/%b want=%h/%b", k, got_q[k], last_q[k], exp_q[k], exp_last_q[k]);
      end
    end
    checks++; if (got_q.size() > 0 && xfer_cyc[0] !== ok_cyc) begin errors++; $display("FAIL good_first_cycle got=%0d want=%0d", xfer_cyc[0], ok_cyc); end
    for (int k = 1; k < xfer_cyc.size(); k++) begin
      checks++;
      if (xfer_cyc[k] !== xfer_cyc[0] + k) begin errors++; $display("FAIL good_consecutive[%0d] got=%0d want=%0d", k, xfer_cyc[k], xfer_cyc[0] + k); end
    end
  endtask

  task automatic test_backpressure();
    bit tmo;
    clear_mon();
    ready_mode = 0;
    idle(2);
    frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_frame(1'b0);
    idle(5);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
      errors++; $display("FAIL stall_hold got=%b/%h/%b want=1/11/0", out_valid, out_data, out_last);
    end
    ready_mode = 2;
    wait_idle(tmo);
    ready_mode = 1;
    model_run();
    checks++; if (tmo) begin errors++; $display("FAIL stall_drain busy stuck got=1 want=0"); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_len got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL stall_byte[%0d] got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_bad_checksum();
    clear_mon();
    frame_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_frame(1'b0);
    idle(3);
    model_run();
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL badchk_err_count got=%0d want=%0d", err_cnt, exp_err); end
    checks++; if (err_code !== exp_code) begin errors++; $display("FAIL badchk_code got=%b want=%b", err_code, exp_code); end
    checks++; if (ov_cnt !== 0 || ok_cnt !== 0) begin errors++; $display("FAIL badchk_no_output got=%0d/%0d want=0/0", ov_cnt, ok_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badchk_busy got=%b want=0", busy); end
  endtask

  task automatic test_bad_length();
    bit tmo;
    clear_mon();
    frame_q = '{8'hA5, 8'h00};
    send_frame(1'b0);
    frame_q = '{8'hA5, 8'h11};
    send_frame(1'b0);
    idle(1);
    checks++; if (busy !== 1'b0 || err_code !== 2'b01) begin errors++; $display("FAIL badlen_state got=%b/%b want=0/01", busy, err_code); end
    frame_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
    send_frame(1'b0);
    wait_idle(tmo);
    model_run();
    checks++; if (tmo) begin errors++; $display("FAIL badlen_drain busy stuck got=1 want=0"); end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL badlen_err_count got=%0d want=%0d", err_cnt, exp_err); end
    checks++; if (err_code !== exp_code) begin errors++; $display("FAIL badlen_code got=%b want=%b", err_code, exp_code); end
    checks++; if (ok_cnt !== exp_ok || got_q.size() !== exp_q.size()) begin errors++; $display("FAIL badlen_next_frame got=%0d/%0d want=%0d/%0d", ok_cnt, got_q.size(), exp_ok, exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL badlen_byte[%0d] got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_timeout();
    bit tmo;
    clear_mon();
    frame_q = '{8'hA5, 8'h02, 8'h10};
    send_frame(1'b0);
    idle(TIMEOUT - 1);
    checks++; if (frame_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early got=%b/%b want=0/1", frame_err, busy); end
    idle(1);
    exp_code = 2'b11;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse got=%b want=1", frame_err); end
    checks++; if (err_code !== exp_code || busy !== 1'b0) begin errors++; $display("FAIL tmo_code got=%b/%b want=%b/0", err_code, busy, exp_code); end
    idle(2);
    stim_q.delete();
    frame_q = '{8'hA5, 8'h02, 8'h10};
    send_frame(1'b0);
    idle(TIMEOUT - 1);
    frame_q = '{8'h20, 8'h32};
    send_frame(1'b0);
    wait_idle(tmo);
    model_run();
    checks++; if (tmo) begin errors++; $display("FAIL tmo_edge_drain busy stuck got=1 want=0"); end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL tmo_edge_err_count got=%0d want=1", err_cnt); end
    checks++; if (ok_cnt !== exp_ok || got_q.size() !== exp_q.size()) begin errors++; $display("FAIL tmo_edge_frame got=%0d/%0d want=%0d/%0d", ok_cnt, got_q.size(), exp_ok, exp_q.size()); end
    checks++; if (err_code !== exp_code) begin errors++; $display("FAIL tmo_edge_code got=%b want=%b", err_code, exp_code); end
  endtask

  task automatic test_overrun();
    bit tmo;
    clear_mon();
    ready_mode = 0;
    idle(2);
    frame_q = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
    send_frame(1'b0);
    send_byte(8'h5A);
    exp_code = 2'b00;
    checks++; if (frame_err !== 1'b1 || err_code !== exp_code) begin errors++; $display("FAIL ovr_pulse got=%b/%b want=1/%b", frame_err, err_code, exp_code); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hAA || busy !== 1'b1) begin errors++; $display("FAIL ovr_send_kept got=%b/%h/%b want=1/aa/1", out_valid, out_data, busy); end
    ready_mode = 1;
    wait_idle(tmo);
    model_run();
    checks++; if (tmo) begin errors++; $display("FAIL ovr_drain busy stuck got=1 want=0"); end
    checks++; if (err_cnt !== 1 || ok_cnt !== exp_ok) begin errors++; $display("FAIL ovr_counts got=%0d/%0d want=1/%0d", err_cnt, ok_cnt, exp_ok); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovr_len got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL ovr_byte[%0d] got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    clear_mon();
    ready_mode = 1;
    idle(2);
    frame_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
    send_frame(1'b0);
    idle(2);
    frame_q = '{8'hA5, 8'h01, 8'h09, 8'h0A};
    send_frame(1'b0);
    wait_idle(tmo);
    model_run();
    checks++; if (tmo) begin errors++; $display("FAIL b2b_drain busy stuck got=1 want=0"); end
    checks++; if (err_cnt !== 0 || ok_cnt !== exp_ok) begin errors++; $display("FAIL b2b_counts got=%0d/%0d want=0/%0d", err_cnt, ok_cnt, exp_ok); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_len got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k] || last_q[k] !== exp_last_q[k]) begin
        errors++; $display("FAIL b2b_byte[%0d] got=%h/%b want=%h/%b", k, got_q[k], last_q[k], exp_q[k], exp_last_q[k]);
      end
    end
  endtask

  task automatic test_random();
    bit tmo;
    clear_mon();
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int r = int'($urandom_range(0, 9));
      frame_q.delete();
      if (r == 0) begin
        logic [7:0] b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        frame_q.push_back(b);
      end else if (r == 1) begin
        frame_q.push_back(8'hA5);
        frame_q.push_back($urandom_range(0, 1) ? 8'h00 : 8'(MAX_LEN + 1 + int'($urandom_range(0, 254 - MAX_LEN))));
      end else begin
        int flen = int'($urandom_range(1, MAX_LEN));
        int s = flen;
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(flen));
        for (int k = 0; k < flen; k++) begin
          logic [7:0] p = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
          frame_q.push_back(p);
          s += int'(p);
        end
        if (r == 2) frame_q.push_back(8'(s % 256) ^ 8'($urandom_range(1, 255)));
        else        frame_q.push_back(8'(s % 256));
      end
      send_frame(1'b1);
      wait_idle(tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rand_drain frame=%0d busy stuck got=1 want=0", f); end
    end
    ready_mode = 1;
    idle(2);
    model_run();
    checks++; if (ok_cnt !== exp_ok) begin errors++; $display("FAIL rand_ok_count got=%0d want=%0d", ok_cnt, exp_ok); end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL rand_err_count got=%0d want=%0d", err_cnt, exp_err); end
    checks++; if (err_code !== exp_code) begin errors++; $display("FAIL rand_code got=%b want=%b", err_code, exp_code); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_len got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k] || last_q[k] !== exp_last_q[k]) begin
        errors++; $display("FAIL rand_byte[%0d] got=%h/%b want=%h/%b", k, got_q[k], last_q[k], exp_q[k], exp_last_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit tmo;
    clear_mon();
    ready_mode = 1;
    frame_q = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_frame(1'b0);
    rst = 1'b0;
    idle(1);
    exp_code = 2'b00;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rstmid_out got=%b/%b/%h want=0/0/00", out_valid, out_last, out_data); end
    checks++; if (frame_ok !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_status got=%b/%b/%b want=0/0/0", frame_ok, frame_err, busy); end
    checks++; if (err_code !== exp_code) begin errors++; $display("FAIL rstmid_code got=%b want=%b", err_code, exp_code); end
    idle(2);
    rst = 1'b1;
    idle(TIMEOUT + 5);
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rstmid_no_err got=%0d want=0", err_cnt); end
    stim_q.delete();
    frame_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_frame(1'b0);
    wait_idle(tmo);
    model_run();
    checks++; if (tmo) begin errors++; $display("FAIL rstmid_drain busy stuck got=1 want=0"); end
    checks++; if (got_q.size() !== exp_q.size() || (got_q.size() > 0 && got_q[0] !== exp_q[0])) begin
      errors++; $display("FAIL rstmid_next_frame got=%0d bytes want=%0d bytes", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_invariants();
    checks++; if (excl_bad !== 0) begin errors++; $display("FAIL ok_err_exclusive got=%0d want=0", excl_bad); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL stall_stability got=%0d want=0", hold_bad); end
    checks++; if (okvalid_bad !== 0) begin errors++; $display("FAIL ok_with_valid got=%0d want=0", okvalid_bad); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
